// File: rtl/core_s2_sequencer_pkg.sv
// Shared types for the stage-2 sequencer: state encoding and a state-class helper.
package core_pkg;

  typedef enum logic [2:0] {
    INIT             = 3'd0,
    FETCH_NEXT       = 3'd1,
    ISSUE_MEM        = 3'd2,
    WAIT_ON_L1DCACHE = 3'd3,
    FINISH           = 3'd4,
    HALT             = 3'd5
  } s2_state_e;

  // The watchdog budget covers both halves of a data-cache access.
  function automatic logic in_mem_access(input s2_state_e s);
    return (s == ISSUE_MEM) || (s == WAIT_ON_L1DCACHE);
  endfunction

endpackage

// File: rtl/core_s2_sequencer_if.sv
// Stage-1 handoff and L1D request/response signals seen by the stage-2 sequencer.
interface core_s2_sequencer_if;

  logic s1_valid;
  logic s2_ready;
  logic instr_is_mem;
  logic instr_writes_rd;
  logic instr_is_halt;
  logic dcache_req_valid;
  logic dcache_req_ready;
  logic dcache_rsp_valid;

  modport master (
    input  s1_valid, instr_is_mem, instr_writes_rd, instr_is_halt,
    input  dcache_req_ready, dcache_rsp_valid,
    output s2_ready, dcache_req_valid
  );

  modport slave (
    output s1_valid, instr_is_mem, instr_writes_rd, instr_is_halt,
    output dcache_req_ready, dcache_rsp_valid,
    input  s2_ready, dcache_req_valid
  );

endinterface

// File: rtl/core_s2_sequencer_watchdog.sv
// Saturating cycle counter that flags when a memory access has used its whole budget.
module core_s2_watchdog #(
  parameter int DCACHE_TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int CntW = $clog2(DCACHE_TIMEOUT);
  localparam logic [CntW-1:0] Last = CntW'(DCACHE_TIMEOUT - 1);

  logic [CntW-1:0] count;

  // Holds at the last value so an accept on the expiry cycle cannot wrap the budget.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && (count != Last)) begin
      count <= count + CntW'(1);
    end
  end

  assign expired = enable && (count == Last);

endmodule

// File: rtl/core_s2_sequencer.sv
// Stage-2 sequencer: accepts one instruction at a time, runs its L1D access, retires it.
module core_s2_sequencer
  import core_pkg::*;
#(
  parameter int INIT_CYCLES    = 4,
  parameter int DCACHE_TIMEOUT = 256
) (
  input  logic                  clk,
  input  logic                  rst_n,
  core_s2_sequencer_if.master   bus,
  input  logic                  halt_req,
  input  logic                  resume,
  output logic                  rd_write_enable,
  output logic                  pc_advance,
  output logic                  halted,
  output logic                  timeout_error
);

  localparam int InitLast = (INIT_CYCLES > 1) ? (INIT_CYCLES - 1) : 0;
  localparam int InitW    = (InitLast > 0) ? $clog2(InitLast + 1) : 1;

  s2_state_e        state;
  logic [InitW-1:0] init_cnt;
  logic             writes_rd_q;
  logic             transfer;
  logic             wd_expired;

  assign transfer = bus.s1_valid && bus.s2_ready;

  core_s2_watchdog #(
    .DCACHE_TIMEOUT(DCACHE_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (transfer),
    .enable (in_mem_access(state)),
    .expired(wd_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= INIT;
      init_cnt      <= '0;
      writes_rd_q   <= 1'b0;
      timeout_error <= 1'b0;
    end else begin
      case (state)
        INIT: begin
          if (init_cnt == InitW'(InitLast)) begin
            state <= FETCH_NEXT;
          end else begin
            init_cnt <= init_cnt + InitW'(1);
          end
        end
        FETCH_NEXT: begin
          if (halt_req) begin
            state <= HALT;
          end else if (bus.s1_valid) begin
            writes_rd_q <= bus.instr_writes_rd;
            if (bus.instr_is_halt) begin
              state <= HALT;
            end else if (bus.instr_is_mem) begin
              state <= ISSUE_MEM;
            end else begin
              state <= FINISH;
            end
          end
        end
        // Progress events are tested before expiry so a last-cycle handshake still completes.
        ISSUE_MEM: begin
          if (bus.dcache_req_ready) begin
            state <= WAIT_ON_L1DCACHE;
          end else if (wd_expired) begin
            state         <= HALT;
            timeout_error <= 1'b1;
          end
        end
        WAIT_ON_L1DCACHE: begin
          if (bus.dcache_rsp_valid) begin
            state <= FINISH;
          end else if (wd_expired) begin
            state         <= HALT;
            timeout_error <= 1'b1;
          end
        end
        FINISH: begin
          state <= halt_req ? HALT : FETCH_NEXT;
        end
        HALT: begin
          if (resume) begin
            state         <= FETCH_NEXT;
            timeout_error <= 1'b0;
          end
        end
        default: begin
          state <= HALT;
        end
      endcase
    end
  end

  assign bus.s2_ready         = (state == FETCH_NEXT) && !halt_req;
  assign bus.dcache_req_valid = (state == ISSUE_MEM);
  assign pc_advance           = (state == FINISH);
  assign rd_write_enable      = (state == FINISH) && writes_rd_q;
  assign halted               = (state == HALT);

endmodule

// File: tb/tb_core_s2_sequencer.sv
// Directed scoreboard bench for core_s2_sequencer with INIT_CYCLES=4, DCACHE_TIMEOUT=8.
module tb_core_s2_sequencer;

  logic clk;
  logic rst_n;
  logic halt_req;
  logic resume;
  logic rd_write_enable;
  logic pc_advance;
  logic halted;
  logic timeout_error;

  core_s2_sequencer_if bus();

  core_s2_sequencer #(
    .INIT_CYCLES   (4),
    .DCACHE_TIMEOUT(8)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .bus            (bus),
    .halt_req       (halt_req),
    .resume         (resume),
    .rd_write_enable(rd_write_enable),
    .pc_advance     (pc_advance),
    .halted         (halted),
    .timeout_error  (timeout_error)
  );

  typedef struct packed {
    logic isHalt;
    logic val;
  } expEvent_t;

  expEvent_t expQ[$];
  int checks = 0;
  int errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=%b expected=%b", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic valid, input logic isMem,
                               input logic writesRd, input logic isHalt);
    bus.s1_valid        = valid;
    bus.instr_is_mem    = isMem;
    bus.instr_writes_rd = writesRd;
    bus.instr_is_halt   = isHalt;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Each retire pulse and each entry into HALT consumes the next expected event.
  expEvent_t monEvent;
  logic      prevHalted = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (pc_advance) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_retire actual=pc_advance expected=no_event");
        end else begin
          monEvent = expQ.pop_front();
          checkOutput("retire_order", monEvent.isHalt, 1'b0);
          checkOutput("retire_rd_we", rd_write_enable, monEvent.val);
        end
      end
      if (halted && !prevHalted) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_halt actual=halted expected=no_event");
        end else begin
          monEvent = expQ.pop_front();
          checkOutput("halt_order", monEvent.isHalt, 1'b1);
          checkOutput("halt_timeout_flag", timeout_error, monEvent.val);
        end
      end
    end
    prevHalted = halted;
  end

  initial begin
    #200000;
    $display("[TB] FAIL sim_timeout actual=running expected=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    rst_n    = 1'b0;
    halt_req = 1'b0;
    resume   = 1'b0;
    applyStimulus(0, 0, 0, 0);
    bus.dcache_req_ready = 1'b0;
    bus.dcache_rsp_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_s2_ready", bus.s2_ready, 1'b0);
    checkOutput("rst_req_valid", bus.dcache_req_valid, 1'b0);
    checkOutput("rst_pc_advance", pc_advance, 1'b0);
    checkOutput("rst_rd_we", rd_write_enable, 1'b0);
    checkOutput("rst_halted", halted, 1'b0);
    checkOutput("rst_timeout", timeout_error, 1'b0);

    rst_n = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      step();
      checkOutput("init_s2_ready", bus.s2_ready, 1'b0);
      checkOutput("init_pc_advance", pc_advance, 1'b0);
      checkOutput("init_req_valid", bus.dcache_req_valid, 1'b0);
    end
    step();
    checkOutput("init_done_ready", bus.s2_ready, 1'b1);

    $display("[TB] ALU op with rd write");
    applyStimulus(1, 0, 1, 0);
    expQ.push_back('{isHalt: 1'b0, val: 1'b1});
    #1 checkOutput("alu_accept", bus.s2_ready, 1'b1);
    step();
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("alu_finish_pc", pc_advance, 1'b1);
    checkOutput("alu_finish_rd", rd_write_enable, 1'b1);
    checkOutput("alu_finish_busy", bus.s2_ready, 1'b0);
    step();
    checkOutput("alu_pc_once", pc_advance, 1'b0);
    checkOutput("alu_ready_again", bus.s2_ready, 1'b1);

    $display("[TB] load with slow accept and early stray response");
    applyStimulus(1, 1, 1, 0);
    expQ.push_back('{isHalt: 1'b0, val: 1'b1});
    step();
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      bus.dcache_rsp_valid = (i == 1);
      bus.dcache_req_ready = (i == 3);
      #1;
      checkOutput("load_req_held", bus.dcache_req_valid, 1'b1);
      checkOutput("load_no_retire", pc_advance, 1'b0);
      step();
    end
    bus.dcache_req_ready = 1'b0;
    bus.dcache_rsp_valid = 1'b0;
    #1 checkOutput("load_req_dropped", bus.dcache_req_valid, 1'b0);
    step();
    bus.dcache_rsp_valid = 1'b1;
    step();
    bus.dcache_rsp_valid = 1'b0;
    #1;
    checkOutput("load_finish_pc", pc_advance, 1'b1);
    checkOutput("load_finish_rd", rd_write_enable, 1'b1);
    step();
    checkOutput("load_ready_again", bus.s2_ready, 1'b1);

    $display("[TB] store without rd write");
    applyStimulus(1, 1, 0, 0);
    expQ.push_back('{isHalt: 1'b0, val: 1'b0});
    step();
    applyStimulus(0, 0, 0, 0);
    bus.dcache_req_ready = 1'b1;
    step();
    bus.dcache_req_ready = 1'b0;
    bus.dcache_rsp_valid = 1'b1;
    step();
    bus.dcache_rsp_valid = 1'b0;
    #1;
    checkOutput("store_finish_pc", pc_advance, 1'b1);
    checkOutput("store_finish_rd", rd_write_enable, 1'b0);
    step();

    $display("[TB] L1D never accepts: watchdog halt");
    applyStimulus(1, 1, 1, 0);
    expQ.push_back('{isHalt: 1'b1, val: 1'b1});
    step();
    applyStimulus(0, 0, 0, 0);
    for (int i = 0; i < 8; i++) begin
      checkOutput("wd_req_valid", bus.dcache_req_valid, 1'b1);
      checkOutput("wd_not_halted", halted, 1'b0);
      step();
    end
    checkOutput("wd_halted", halted, 1'b1);
    checkOutput("wd_error_set", timeout_error, 1'b1);
    checkOutput("wd_no_retire", pc_advance, 1'b0);
    resume = 1'b1;
    step();
    resume = 1'b0;
    #1;
    checkOutput("wd_error_cleared", timeout_error, 1'b0);
    checkOutput("wd_resume_ready", bus.s2_ready, 1'b1);

    $display("[TB] response on the expiry cycle");
    applyStimulus(1, 1, 1, 0);
    expQ.push_back('{isHalt: 1'b0, val: 1'b1});
    step();
    applyStimulus(0, 0, 0, 0);
    bus.dcache_req_ready = 1'b1;
    step();
    bus.dcache_req_ready = 1'b0;
    repeat (6) step();
    checkOutput("edge_still_waiting", halted, 1'b0);
    bus.dcache_rsp_valid = 1'b1;
    step();
    bus.dcache_rsp_valid = 1'b0;
    #1;
    checkOutput("edge_retires", pc_advance, 1'b1);
    checkOutput("edge_no_timeout", timeout_error, 1'b0);
    step();

    $display("[TB] resume outside HALT");
    resume = 1'b1;
    step();
    resume = 1'b0;
    #1;
    checkOutput("stray_resume_ready", bus.s2_ready, 1'b1);
    checkOutput("stray_resume_halted", halted, 1'b0);

    $display("[TB] halt request beats a valid instruction");
    applyStimulus(1, 0, 1, 0);
    halt_req = 1'b1;
    expQ.push_back('{isHalt: 1'b1, val: 1'b0});
    #1 checkOutput("halt_blocks_ready", bus.s2_ready, 1'b0);
    step();
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("halt_req_halted", halted, 1'b1);
    checkOutput("halt_req_no_retire", pc_advance, 1'b0);
    halt_req = 1'b0;
    resume   = 1'b1;
    step();
    resume = 1'b0;
    #1 checkOutput("halt_req_resumed", bus.s2_ready, 1'b1);

    $display("[TB] halt request during an access");
    applyStimulus(1, 1, 0, 0);
    expQ.push_back('{isHalt: 1'b0, val: 1'b0});
    expQ.push_back('{isHalt: 1'b1, val: 1'b0});
    step();
    applyStimulus(0, 0, 0, 0);
    bus.dcache_req_ready = 1'b1;
    step();
    bus.dcache_req_ready = 1'b0;
    halt_req = 1'b1;
    step();
    bus.dcache_rsp_valid = 1'b1;
    step();
    bus.dcache_rsp_valid = 1'b0;
    #1;
    checkOutput("wait_halt_retires", pc_advance, 1'b1);
    checkOutput("wait_halt_not_yet", halted, 1'b0);
    step();
    checkOutput("wait_halt_halted", halted, 1'b1);
    halt_req = 1'b0;
    resume   = 1'b1;
    step();
    resume = 1'b0;

    $display("[TB] ebreak class");
    applyStimulus(1, 1, 1, 1);
    expQ.push_back('{isHalt: 1'b1, val: 1'b0});
    #1 checkOutput("ebreak_accept", bus.s2_ready, 1'b1);
    step();
    applyStimulus(0, 0, 0, 0);
    #1;
    checkOutput("ebreak_halted", halted, 1'b1);
    checkOutput("ebreak_no_pc", pc_advance, 1'b0);
    checkOutput("ebreak_no_rd", rd_write_enable, 1'b0);
    checkOutput("ebreak_no_req", bus.dcache_req_valid, 1'b0);
    resume = 1'b1;
    step();
    resume = 1'b0;

    $display("[TB] reset during an access");
    applyStimulus(1, 1, 1, 0);
    step();
    applyStimulus(0, 0, 0, 0);
    #1 checkOutput("midrst_req_before", bus.dcache_req_valid, 1'b1);
    rst_n = 1'b0;
    #1 checkOutput("midrst_req_dropped", bus.dcache_req_valid, 1'b0);
    step();
    checkOutput("midrst_req_stays_low", bus.dcache_req_valid, 1'b0);
    rst_n = 1'b1;
    step();
    checkOutput("midrst_in_init", bus.s2_ready, 1'b0);
    repeat (2) step();

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL pending_events actual=%0d expected=0", expQ.size());
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
